// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: stimulus/capture bus between a sweep controller and the sweeper
interface truth_table_sweeper_if;
   logic       start;
   logic [7:0] expected;
   logic       gate_out;
   logic       in1, in2, in3;
   logic       busy;
   logic       done;
   logic [7:0] table_out;
   logic       match;
   logic [7:0] mismatch_mask;

   modport master (
      output start, expected, gate_out,
      input  in1, in2, in3, busy, done, table_out, match, mismatch_mask
   );

   modport slave (
      input  start, expected, gate_out,
      output in1, in2, in3, busy, done, table_out, match, mismatch_mask
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 3-input gate through 000..111, captures its truth table and checks it
module truth_table_sweeper #(
   parameter int SETTLE_CYCLES = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   truth_table_sweeper_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
   localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

   state_t     state, state_n;
   logic [2:0] idx, idx_n, ins, drv;
   logic [7:0] cnt, cnt_n, tbl, tbl_n, exp_l, exp_n, mask, mask_n;
   logic       match, match_n, busy, done;

   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      tbl_n   = tbl;
      exp_n   = exp_l;
      match_n = match;
      mask_n  = mask;
      case (state)
         IDLE:
            if (bus.start) begin
               state_n = SETTLE;
               idx_n   = 3'd0;
               cnt_n   = CNT_INIT;
               tbl_n   = 8'h00;
               exp_n   = bus.expected;
               match_n = 1'b0;
               mask_n  = 8'h00;
            end
         SETTLE:
            if (cnt == 8'd0) state_n = SAMPLE;
            else cnt_n = cnt - 8'd1;
         SAMPLE: begin
            tbl_n[idx] = bus.gate_out;
            // compare against the table including this final capture
            if (idx == 3'd7) begin
               state_n = DONE;
               match_n = (tbl_n == exp_l);
               mask_n  = tbl_n ^ exp_l;
            end else begin
               state_n = SETTLE;
               idx_n   = idx + 3'd1;
               cnt_n   = CNT_INIT;
            end
         end
         DONE:
            state_n = IDLE;
      endcase
   end

   assign drv = (state_n == SETTLE || state_n == SAMPLE) ? idx_n : 3'd0;

   always_ff @(posedge clk)
      if (!rst_n) begin
         idx   <= 3'd0;
         cnt   <= 8'd0;
         tbl   <= 8'h00;
         exp_l <= 8'h00;
         match <= 1'b0;
         mask  <= 8'h00;
         ins   <= 3'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         idx   <= idx_n;
         cnt   <= cnt_n;
         tbl   <= tbl_n;
         exp_l <= exp_n;
         match <= match_n;
         mask  <= mask_n;
         ins   <= drv;
         busy  <= (state_n != IDLE);
         done  <= (state_n == DONE);
      end

   assign {bus.in1, bus.in2, bus.in3} = ins;
   assign bus.busy          = busy;
   assign bus.done          = done;
   assign bus.table_out     = tbl;
   assign bus.match         = match;
   assign bus.mismatch_mask = mask;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps against a modelled gate, scoreboard-checked on done
module tb_truth_table_sweeper;
   localparam int S = 4;
   localparam int P = S + 1;

   typedef struct {
      int         t;
      logic [7:0] tbl;
      logic [7:0] msk;
      logic       m;
   } exp_t;

   logic       clk = 0;
   logic       rst_n = 0;
   logic [1:0] mode = 0;
   logic       tog = 0;
   logic       f;
   logic       active = 0;
   int         cyc = 0;
   int         e0 = 0;
   int         k;
   int         n_vec = 0;
   int         n_bad = 0;
   exp_t       sb[$];

   truth_table_sweeper_if bus ();

   truth_table_sweeper #(.SETTLE_CYCLES(S)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      tog <= ~tog;
   end

   // mode 3 scrambles gate_out while settling, with the wrong value just before the sample cycle
   assign k = cyc - e0;
   assign f = bus.in2 & (bus.in1 | bus.in3);
   assign bus.gate_out = mode == 2'd0 ? f :
                         mode == 2'd1 ? 1'b1 :
                         mode == 2'd2 ? 1'b0 :
                         (k % P == P - 1) ? f :
                         (k % P == P - 2) ? ~f : tog;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, want, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (active && k >= 0 && k < 8 * P)
               chk("busy_inputs", {bus.busy, bus.in1, bus.in2, bus.in3}, {1'b1, 3'(k / P)});
            if (bus.done) begin
               if (sb.size() == 0) chk("spurious_done", {31'd0, bus.done}, 32'd0);
               else begin
                  e = sb.pop_front();
                  chk("done_cycle", cyc, e.t);
                  chk("table_out", bus.table_out, e.tbl);
                  chk("match", bus.match, e.m);
                  chk("mismatch_mask", bus.mismatch_mask, e.msk);
               end
            end
         end
      end
   endtask

   task automatic push(input logic [7:0] ex, input logic [7:0] tbl);
      exp_t e;
      e.t = e0 + 8 * P;
      e.tbl = tbl;
      e.msk = tbl ^ ex;
      e.m = (tbl == ex);
      sb.push_back(e);
   endtask

   task automatic issue(input logic [7:0] ex, input logic [7:0] tbl);
      @(negedge clk);
      bus.expected = ex;
      bus.start = 1;
      @(posedge clk);
      #1;
      bus.start = 0;
      bus.expected = ~ex;
      e0 = cyc;
      active = 1;
      push(ex, tbl);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         chk("done_timeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      bus.start = 0;
      bus.expected = 0;
      fork
         monitor();
      join_none
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {bus.in1, bus.in2, bus.in3, bus.busy, bus.done, bus.match,
                            bus.table_out, bus.mismatch_mask}, 32'd0);
      rst_n = 1;

      mode = 0; issue(8'hC8, 8'hC8); wait_empty();
      mode = 1; issue(8'h00, 8'hFF); wait_empty();
      mode = 2; issue(8'h00, 8'h00); wait_empty();
      mode = 3; issue(8'hC8, 8'hC8); wait_empty();

      mode = 0;
      issue(8'hC8, 8'hC8);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.start = 1;
      @(posedge clk);
      #1;
      bus.start = 0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.expected = 8'hC8;
      bus.start = 1;
      repeat (22) @(posedge clk);
      @(negedge clk);
      chk("idle_gap_busy_table", {bus.busy, bus.table_out}, {1'b0, 8'hC8});
      @(posedge clk);
      #1;
      bus.start = 0;
      e0 = cyc;
      push(8'hC8, 8'hC8);
      @(negedge clk);
      chk("restart_clear", {bus.busy, bus.match, bus.table_out, bus.mismatch_mask},
          {1'b1, 1'b0, 8'h00, 8'h00});
      wait_empty();

      issue(8'hC8, 8'hC8);
      repeat (16) @(posedge clk);
      @(negedge clk);
      rst_n = 0;
      active = 0;
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1;
      @(negedge clk);
      chk("mid_reset", {bus.in1, bus.in2, bus.in3, bus.busy, bus.done, bus.match,
                        bus.table_out, bus.mismatch_mask}, 32'd0);
      issue(8'h48, 8'hC8);
      wait_empty();

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
